// File: rtl/dcache_uncached_responder.sv
// rtl/dcache_uncached_responder.sv - single-beat AXI responder for uncached MEM-stage loads/stores
module dcache_uncached_responder #(
    parameter int ID_W        = 4,
    parameter bit TIMEOUT_EN  = 1'b0,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic        cpu_op,
    input  logic [31:0] cpu_paddr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    input  logic        mem_wr,
    output logic        cpu_busy,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        bus_err,
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic        rready,
    output logic        awvalid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    input  logic        awready,
    output logic        wvalid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready
);

    // Fixed single-beat INCR burst fields and zero IDs for the uncached port.
    localparam logic [7:0]      AXI_LEN   = 8'd0;
    localparam logic [1:0]      AXI_BURST = 2'b01;
    localparam logic [ID_W-1:0] AXI_ID    = '0;
    localparam logic [9:0]      TO_LAST   = 10'(TIMEOUT_CYC - 1);
    localparam logic [31:0]     ERR_WORD  = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        op_q;
    logic        aw_done;
    logic        w_done;
    logic [9:0]  wait_cnt;

    logic aw_hs;
    logic w_hs;
    logic wr_both;
    logic resp_wait;
    logic resp_fire;
    logic resp_err;
    logic timeout_hit;

    logic unused_ok;
    assign unused_ok = &{1'b0, rlast, AXI_LEN, AXI_BURST, AXI_ID};

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign wlast  = 1'b1;

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign wr_both     = (aw_done || aw_hs) && (w_done || w_hs);
    assign resp_wait   = (state == RD_DATA) || (state == WR_RESP);
    assign resp_fire   = resp_wait && (op_q ? bvalid : rvalid);
    assign resp_err    = op_q ? (bresp != 2'b00) : (rresp != 2'b00);
    // A response arriving in the last allowed cycle still wins over the timeout.
    assign timeout_hit = TIMEOUT_EN && resp_wait && !resp_fire && (wait_cnt == TO_LAST);

    always_comb begin
        state_n  = state;
        cpu_busy = 1'b0;
        case (state)
            IDLE: begin
                cpu_busy = cpu_valid;
                if (cpu_valid) begin
                    state_n = cpu_op ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                cpu_busy = 1'b1;
                if (arvalid && arready) begin
                    state_n = RD_DATA;
                end
            end
            RD_DATA, WR_RESP: begin
                cpu_busy = 1'b1;
                if (resp_fire || timeout_hit) begin
                    state_n = DONE;
                end
            end
            WR_REQ: begin
                cpu_busy = 1'b1;
                if (wr_both) begin
                    state_n = WR_RESP;
                end
            end
            DONE: begin
                if (mem_wr) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            cpu_rdata  <= 32'd0;
            cpu_rvalid <= 1'b0;
            bus_err    <= 1'b0;
            wait_cnt   <= 10'd0;
            addr_q     <= 32'd0;
            size_q     <= 2'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            op_q       <= 1'b0;
        end else begin
            state   <= state_n;
            arvalid <= (state_n == RD_ADDR);
            rready  <= (state_n == RD_DATA);
            bready  <= (state_n == WR_RESP);

            if (TIMEOUT_EN && resp_wait && (state_n == state)) begin
                wait_cnt <= wait_cnt + 10'd1;
            end else begin
                wait_cnt <= 10'd0;
            end

            case (state)
                IDLE: begin
                    if (cpu_valid) begin
                        addr_q  <= cpu_paddr;
                        size_q  <= cpu_size;
                        wdata_q <= cpu_wdata;
                        wstrb_q <= cpu_wstrb;
                        op_q    <= cpu_op;
                        awvalid <= cpu_op;
                        wvalid  <= cpu_op;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; either may finish first.
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                end
                RD_DATA, WR_RESP: begin
                    if (resp_fire) begin
                        if (!op_q) begin
                            cpu_rdata  <= rdata;
                            cpu_rvalid <= 1'b1;
                        end
                        if (TIMEOUT_EN && resp_err) begin
                            bus_err <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        bus_err    <= 1'b1;
                        cpu_rdata  <= ERR_WORD;
                        cpu_rvalid <= !op_q;
                    end
                end
                DONE: begin
                    if (mem_wr) begin
                        cpu_rvalid <= 1'b0;
                        bus_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_uncached_responder.sv
// tb/tb_dcache_uncached_responder.sv - scoreboard bench with randomized AXI slave timing
module tb_dcache_uncached_responder;

    localparam int TO_CYC = 8;
    localparam int NEVER  = 100;
    localparam int ABORT  = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_valid = 1'b0, cpu_op = 1'b0, mem_wr = 1'b0;
    logic [31:0] cpu_paddr = '0, cpu_wdata = '0;
    logic [1:0]  cpu_size = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic        cpu_busy, cpu_rvalid, bus_err;
    logic [31:0] cpu_rdata;
    logic        arvalid, arready = 1'b0;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        rvalid = 1'b0, rlast = 1'b0, rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        awvalid, awready = 1'b0;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        wvalid, wlast, wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0, bready;
    logic [1:0]  bresp = '0;

    always #5 clk = ~clk;

    dcache_uncached_responder #(.ID_W(4), .TIMEOUT_EN(1'b1), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_op(cpu_op), .cpu_paddr(cpu_paddr),
        .cpu_size(cpu_size), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .mem_wr(mem_wr),
        .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .bus_err(bus_err),
        .arvalid(arvalid), .araddr(araddr), .arsize(arsize), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready),
        .awvalid(awvalid), .awaddr(awaddr), .awsize(awsize), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready)
    );

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ar_d, aw_d, w_d, rb_d;
        logic        err;
        int          hold;
    } txn_t;

    typedef struct {
        logic        is_rd;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
    } exp_t;

    txn_t        slave_q[$];
    exp_t        exp_q[$];
    logic [31:0] mdl_mem [logic [29:0]];
    logic [31:0] slv_mem [logic [29:0]];
    int n_pass = 0, n_total = 0;
    int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    int exp_ar = 0, exp_r = 0, exp_aw = 0, exp_b = 0;
    bit mon_skip = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mdl_word(input logic [29:0] w);
        return mdl_mem.exists(w) ? mdl_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] slv_word(input logic [29:0] w);
        return slv_mem.exists(w) ? slv_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic txn_t mk(input logic op, input logic [31:0] addr, input logic [1:0] size,
                                input logic [31:0] wd, input logic [3:0] ws, input int ar_d,
                                input int aw_d, input int w_d, input int rb_d, input logic err,
                                input int hold);
        txn_t t;
        t.op = op; t.addr = addr; t.size = size; t.wdata = wd; t.wstrb = ws;
        t.ar_d = ar_d; t.aw_d = aw_d; t.w_d = w_d; t.rb_d = rb_d; t.err = err; t.hold = hold;
        return t;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            if (arvalid && arready) ar_hs <= ar_hs + 1;
            if (rvalid && rready)   r_hs  <= r_hs + 1;
            if (awvalid && awready) aw_hs <= aw_hs + 1;
            if (wvalid && wready)   w_hs  <= w_hs + 1;
            if (bvalid && bready)   b_hs  <= b_hs + 1;
        end
    end

    // Monitor: a falling cpu_busy marks the DONE entry; compare against the oldest expectation.
    initial begin : monitor
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_busy && !cpu_busy && !mon_skip && !rst) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: completion seen, required a pending scoreboard entry");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rvalid", cpu_rvalid, e.is_rd);
                    check("rsp_bus_err", bus_err, e.err);
                    if (e.chk_data) check("rsp_rdata", cpu_rdata, e.data);
                end
            end
            prev_busy = cpu_busy;
        end
    end

    task automatic slave_read(input txn_t t);
        int cnt;
        logic [29:0] w;
        check("ar_addr", araddr, t.addr);
        check("ar_size", arsize, {1'b0, t.size});
        w = araddr[31:2];
        for (int i = 0; i < t.ar_d; i++) begin
            @(negedge clk);
            check("ar_hold", {arvalid, araddr}, {1'b1, t.addr});
        end
        arready = 1'b1;
        @(posedge clk);
        #1 arready = 1'b0;
        @(negedge clk);
        check("rd_data_entry", rready, 1);
        if (t.rb_d == ABORT) return;
        if (t.rb_d == NEVER) begin
            cnt = 0;
            while (rready && cnt < 50) begin cnt++; @(negedge clk); end
            check("rd_timeout_cycles", cnt, TO_CYC);
            return;
        end
        for (int i = 0; i < t.rb_d; i++) @(negedge clk);
        rvalid = 1'b1; rdata = slv_word(w); rresp = t.err ? 2'b10 : 2'b00; rlast = 1'b1;
        @(posedge clk);
        #1 rvalid = 1'b0; rdata = $urandom; rresp = 2'b00; rlast = 1'b0;
    endtask

    task automatic slave_write(input txn_t t);
        bit aw_ok, w_ok;
        int cyc, cnt;
        check("aw_addr", awaddr, t.addr);
        check("aw_size", awsize, {1'b0, t.size});
        check("w_fields", {wdata, wstrb, wlast}, {t.wdata, t.wstrb, 1'b1});
        aw_ok = 0; w_ok = 0; cyc = 0;
        while (!(aw_ok && w_ok) && cyc < 60) begin
            check("wr_valids", {awvalid, wvalid}, {!aw_ok, !w_ok});
            awready = !aw_ok && cyc >= t.aw_d;
            wready  = !w_ok && cyc >= t.w_d;
            if (awready) aw_ok = 1;
            if (wready) begin
                slv_mem[awaddr[31:2]] = merge(slv_word(awaddr[31:2]), wdata, wstrb);
                w_ok = 1;
            end
            @(negedge clk);
            cyc++;
        end
        awready = 1'b0; wready = 1'b0;
        check("wr_resp_entry", bready, 1);
        if (t.rb_d == NEVER) begin
            cnt = 0;
            while (bready && cnt < 50) begin cnt++; @(negedge clk); end
            check("wr_timeout_cycles", cnt, TO_CYC);
            return;
        end
        for (int i = 0; i < t.rb_d; i++) @(negedge clk);
        bvalid = 1'b1; bresp = t.err ? 2'b10 : 2'b00;
        @(posedge clk);
        #1 bvalid = 1'b0; bresp = 2'b00;
    endtask

    initial begin : slave
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst && slave_q.size() > 0 && (arvalid || awvalid || wvalid)) begin
                t = slave_q.pop_front();
                if (t.op) slave_write(t);
                else slave_read(t);
            end
        end
    end

    task automatic drive_req(input txn_t t);
        cpu_valid = 1'b1; cpu_op = t.op; cpu_paddr = t.addr; cpu_size = t.size;
        cpu_wdata = t.wdata; cpu_wstrb = t.wstrb;
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of a later IDLE cycle.
    task automatic issue(input txn_t t);
        exp_t e;
        logic [29:0] w;
        logic [31:0] rd0;
        int cyc;
        w = t.addr[31:2];
        if (!t.op) begin
            exp_ar++;
            if (t.rb_d < NEVER) exp_r++;
            e.is_rd = 1'b1; e.chk_data = 1'b1;
            if (t.rb_d == NEVER) begin e.data = 32'hDEAD_BEEF; e.err = 1'b1; end
            else begin e.data = mdl_word(w); e.err = t.err; end
        end else begin
            exp_aw++;
            if (t.rb_d < NEVER) exp_b++;
            mdl_mem[w] = merge(mdl_word(w), t.wdata, t.wstrb);
            e.is_rd = 1'b0; e.chk_data = (t.rb_d == NEVER); e.data = 32'hDEAD_BEEF;
            e.err = (t.rb_d == NEVER) || t.err;
        end
        exp_q.push_back(e);
        slave_q.push_back(t);
        drive_req(t);
        @(negedge clk);
        check("busy_on_request", cpu_busy, 1);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (cpu_busy && cyc < 200);
        check("done_reached", cpu_busy, 0);
        rd0 = cpu_rdata;
        for (int h = 0; h < t.hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("hold_quiet", {arvalid, awvalid, wvalid, cpu_busy}, 0);
            check("hold_rdata", cpu_rdata, rd0);
        end
        @(posedge clk);
        #1 mem_wr = 1'b1;
        @(posedge clk);
        #1 mem_wr = 1'b0; cpu_valid = 1'b0;
        @(negedge clk);
        check("idle_after_mem_wr", {cpu_rvalid, bus_err, cpu_busy, arvalid, awvalid}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_read();
        int cyc;
        exp_ar++;
        slave_q.push_back(mk(1'b0, 32'h1FAF_F020, 2'd2, 32'd0, 4'd0, 1, 0, 0, ABORT, 1'b0, 0));
        mon_skip = 1'b1;
        drive_req(mk(1'b0, 32'h1FAF_F020, 2'd2, 32'd0, 4'd0, 1, 0, 0, ABORT, 1'b0, 0));
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!rready && cyc < 50);
        check("rst_reached_rd_data", rready, 1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1; cpu_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_read", {arvalid, rready, awvalid, wvalid, bready, cpu_rvalid, bus_err, cpu_busy}, 0);
        @(posedge clk);
        #1 mon_skip = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time bound exceeded");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        txn_t t;
        int rb;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_axi_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        check("reset_cpu_outs", {cpu_rdata, cpu_rvalid, bus_err, cpu_busy}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        mdl_mem[30'(32'h1FAF_F000 >> 2)] = 32'h1234_5678;
        slv_mem[30'(32'h1FAF_F000 >> 2)] = 32'h1234_5678;
        issue(mk(1'b0, 32'h1FAF_F000, 2'd2, 32'd0, 4'd0, 3, 0, 0, 2, 1'b0, 0));
        issue(mk(1'b1, 32'h1FAF_F003, 2'd0, 32'hAB00_0000, 4'b1000, 0, 3, 0, 1, 1'b0, 0));
        issue(mk(1'b1, 32'h1FAF_F010, 2'd2, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 5, 1'b0, 0));
        issue(mk(1'b0, 32'h1FAF_F000, 2'd2, 32'd0, 4'd0, 0, 0, 0, 0, 1'b0, 4));
        issue(mk(1'b0, 32'h1FAF_F010, 2'd1, 32'd0, 4'd0, 1, 0, 0, TO_CYC - 1, 1'b0, 0));
        issue(mk(1'b1, 32'h1FAF_F008, 2'd1, 32'h5555_AAAA, 4'b0011, 2, 1, 2, TO_CYC - 1, 1'b0, 1));
        reset_mid_read();
        issue(mk(1'b0, 32'h1FAF_F003, 2'd0, 32'd0, 4'd0, 0, 0, 0, 1, 1'b0, 0));
        issue(mk(1'b0, 32'h1FAF_F004, 2'd2, 32'd0, 4'd0, 0, 0, 0, NEVER, 1'b0, 2));
        issue(mk(1'b1, 32'h1FAF_F00C, 2'd2, 32'h0BAD_F00D, 4'hF, 0, 1, 1, NEVER, 1'b0, 0));
        issue(mk(1'b0, 32'h1FAF_F014, 2'd2, 32'd0, 4'd0, 1, 0, 0, 2, 1'b1, 0));
        issue(mk(1'b1, 32'h1FAF_F018, 2'd2, 32'h1111_2222, 4'hF, 0, 0, 1, 3, 1'b1, 0));

        for (int n = 0; n < 40; n++) begin
            rb = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 7));
            t = mk(1'($urandom_range(0, 1)), 32'h1FAF_F000 + 32'($urandom_range(0, 63)),
                   2'($urandom_range(0, 2)), $urandom, 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   rb, 1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));
            issue(t);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("slave_queue_drained", slave_q.size(), 0);
        check("ar_handshakes", ar_hs, exp_ar);
        check("r_handshakes", r_hs, exp_r);
        check("aw_handshakes", aw_hs, exp_aw);
        check("w_handshakes", w_hs, exp_aw);
        check("b_handshakes", b_hs, exp_b);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcache_uncached_responder.md
Name: dcache_uncached_responder

Overview:
- Responder end of the MEM-stage CPU data bus for uncached accesses: takes the single outstanding load/store request the MEM stage drives (valid, op, address, wdata, wstrb, size).
- Translates it into one single-beat AXI read or write on the uncached AXI port.
- Returns read data and a busy/stall indication to the pipeline.
- Sits between MEM-stage bus signals and the uncached AXI channel; the cached path is handled elsewhere.

Parameters:
- ID_W, 4, AXI ID width; all IDs driven as 0.
- TIMEOUT_EN, 0, when 1 the bus_err output and the response-wait counter are enabled.
- TIMEOUT_CYC, 1023, maximum cycles to wait for an R or B response before bus_err (only when TIMEOUT_EN=1).

Ports:
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- cpu_valid in 1: request present (load or store).
- cpu_op in 1: 0 = read, 1 = write.
- cpu_paddr in 32: physical address.
- cpu_size in 2: 0 = byte, 1 = half, 2 = word.
- cpu_wdata in 32: lane-aligned store data.
- cpu_wstrb in 4: byte enables.
- mem_wr in 1: pipeline advance; consumes a completed result.
- cpu_busy out 1: stall MEM.
- cpu_rdata out 32: raw read word.
- cpu_rvalid out 1: read data valid.
- bus_err out 1: timeout flag.
- arvalid out 1; araddr out 32; arsize out 3; arready in 1.
- rvalid in 1; rdata in 32; rresp in 2; rlast in 1; rready out 1.
- awvalid out 1; awaddr out 32; awsize out 3; awready in 1.
- wvalid out 1; wdata out 32; wstrb out 4; wlast out 1; wready in 1.
- bvalid in 1; bresp in 2; bready out 1.

Behaviour:
- **FSM states:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- **Reset:** rst forces IDLE on the next edge, including mid-transaction. Reset values: all AXI valid/ready outputs 0, cpu_rdata 0, cpu_rvalid 0, bus_err 0, internal aw_done/w_done 0. A global reset is allowed to abandon an in-flight AXI transaction.
- **cpu_busy (combinational):**
  - 1 in IDLE while cpu_valid=1, so the request stalls in its first cycle.
  - 1 in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
  - 0 in DONE, and 0 in IDLE with cpu_valid=0.
- **Request capture (IDLE, cpu_valid=1):** latch paddr, size, wdata, wstrb and op into registers.
  - op=0: go to RD_ADDR.
  - op=1: go to WR_REQ.
- **Registered AXI fields:**
  - araddr = awaddr = captured paddr, unmodified; no alignment forcing.
  - arsize = awsize = {1'b0, size}.
  - wdata and wstrb come from the captured values; wlast = 1.
  - Burst length is always 1 (len=0, burst=INCR).
- **RD_ADDR:** arvalid=1 and is held stable until arready=1. On the handshake, go to RD_DATA.
- **RD_DATA:** rready=1. On rvalid=1, capture rdata into cpu_rdata, set cpu_rvalid=1, and go to DONE. rresp is ignored except that a nonzero value sets bus_err when TIMEOUT_EN=1.
- **WR_REQ:** awvalid and wvalid are asserted together.
  - Each channel drops independently after its own handshake, tracked with aw_done/w_done.
  - If both handshakes occur in the same cycle, or the second one completes, go to WR_RESP.
  - W before AW is legal.
- **WR_RESP:** bready=1. On bvalid=1, go to DONE.
- **DONE:**
  - cpu_busy=0. cpu_rdata and cpu_rvalid are held (cpu_rvalid stays 0 for writes).
  - On mem_wr=1, go to IDLE and clear cpu_rvalid.
  - With mem_wr=0 (stall from another stage), remain in DONE indefinitely. Never reissue while the same request is still presented.
- **Back-to-back:** a new request is seen only in IDLE, so there is at least one IDLE cycle between transactions. cpu_valid must be sampled in IDLE only.
- **Timeout (TIMEOUT_EN=1):**
  - A 10-bit counter resets on entry to RD_DATA or WR_RESP and increments each waiting cycle.
  - On reaching TIMEOUT_CYC: set bus_err=1, go to DONE, and set cpu_rdata = 32'hDEAD_BEEF.
  - bus_err clears on the IDLE transition.
- **Protocol rules:** no combinational path from AXI ready/valid inputs to AXI valid outputs. The only combinational output is cpu_busy.

Test Plan:
- **Word read:** cpu_valid=1, op=0, paddr=0x1FAF_F000, size=2; arready delayed 3 cycles; rdata=0x1234_5678 -> araddr 0x1FAF_F000, arsize 2, cpu_rdata=0x1234_5678, cpu_busy falls in the DONE cycle, one AR only.
- **Byte write:** op=1, paddr=0x1FAF_F003, size=0, wdata=0xAB00_0000, wstrb=4'b1000; wready before awready -> W accepted first, AW later, awaddr 0x1FAF_F003, awsize 0, exactly one AW/W/B, returns to IDLE after mem_wr.
- **Same-cycle handshake:** awready=wready=1 in the first WR_REQ cycle -> WR_RESP entered next cycle; bvalid after 5 cycles -> DONE.
- **DONE hold:** read completes, mem_wr held 0 for 4 cycles -> no new arvalid, cpu_rdata stable; mem_wr=1 -> IDLE and cpu_rvalid=0.
- **Reset mid-read:** rst=1 in RD_DATA -> next cycle all AXI valids and cpu_rvalid are 0, state IDLE; a following read works normally.
- **Timeout:** TIMEOUT_EN=1, TIMEOUT_CYC=8, rvalid never asserted -> bus_err=1 and cpu_rdata=0xDEAD_BEEF after 8 wait cycles in RD_DATA.
